// File: rtl/rider_detect.sv
// Rider-presence / steering-enable controller: registers load-cell sum and |diff| per
// strobe, then runs IDLE/WAIT/STEER_EN with a settle timer. Define RIDER_FAST_SIM_EN for a 2^15-1 cycle settle.
module rider_detect #(
    parameter logic [12:0] MIN_RIDER_WT = 13'h0200,
    parameter logic [12:0] WT_HYST      = 13'h0040
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [11:0] lft_ld,
    input  logic [11:0] rght_ld,
    input  logic        ld_vld,
    output logic        en_steer,
    output logic        rider_off
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT     = 2'd1,
        STEER_EN = 2'd2
    } state_t;

    localparam logic [12:0] ON_THRESH  = MIN_RIDER_WT + WT_HYST;
    localparam logic [12:0] OFF_THRESH = MIN_RIDER_WT - WT_HYST;

    logic [12:0] sum_q,  sum_d;
    logic [12:0] diff_q, diff_d;
    logic [25:0] tmr_q,  tmr_d;
    state_t      state_q, state_d;

    logic on_wt, off_wt, unbal, step_off, tmr_full;

    always_comb begin
        sum_d  = sum_q;
        diff_d = diff_q;
        if (ld_vld) begin
            sum_d  = {1'b0, lft_ld} + {1'b0, rght_ld};
            diff_d = (lft_ld >= rght_ld) ? {1'b0, lft_ld - rght_ld}
                                         : {1'b0, rght_ld - lft_ld};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum_q  <= '0;
            diff_q <= '0;
        end else begin
            sum_q  <= sum_d;
            diff_q <= diff_d;
        end
    end

    assign on_wt    = sum_q > ON_THRESH;
    assign off_wt   = sum_q < OFF_THRESH;
    assign unbal    = diff_q > {2'b00, sum_q[12:2]};
    assign step_off = diff_q > (sum_q - {4'b0000, sum_q[12:4]});

`ifdef RIDER_FAST_SIM_EN
    assign tmr_full = &tmr_q[14:0];
`else
    assign tmr_full = &tmr_q;
`endif

    // Off-weight is tested first in WAIT and STEER_EN so a dismount always wins.
    always_comb begin
        state_d = state_q;
        tmr_d   = tmr_q;
        case (state_q)
            IDLE: begin
                if (on_wt) begin
                    state_d = WAIT;
                    tmr_d   = '0;
                end
            end
            WAIT: begin
                if (off_wt) begin
                    state_d = IDLE;
                end else if (unbal) begin
                    tmr_d = '0;
                end else if (tmr_full) begin
                    state_d = STEER_EN;
                end else begin
                    tmr_d = tmr_q + 26'd1;
                end
            end
            STEER_EN: begin
                if (off_wt) begin
                    state_d = IDLE;
                end else if (step_off) begin
                    state_d = WAIT;
                    tmr_d   = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs are registered alongside the state so they track it with no decode glitches.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            tmr_q     <= '0;
            en_steer  <= 1'b0;
            rider_off <= 1'b1;
        end else begin
            state_q   <= state_d;
            tmr_q     <= tmr_d;
            en_steer  <= (state_d == STEER_EN);
            rider_off <= (state_d == IDLE);
        end
    end

endmodule

// File: tb/tb_rider_detect.sv
// Scoreboard bench for rider_detect: each strobe pushes its expected outputs, checked two
// edges later; settle timing is measured in clk edges.
module tb_rider_detect;

    localparam logic [25:0] TMR_ALL = 26'h3FF_FFFF;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [11:0] lft_ld = '0;
    logic [11:0] rght_ld = '0;
    logic        ld_vld = 1'b0;
    logic        en_steer;
    logic        rider_off;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        string       tag;
        logic        en;
        logic        off;
        logic [12:0] sum;
        logic [12:0] diff;
    } txn_t;

    txn_t sb_q[$];
    logic vld_d1 = 1'b0;
    logic vld_d2 = 1'b0;

    rider_detect dut (
        .clk       (clk),
        .rst       (rst),
        .lft_ld    (lft_ld),
        .rght_ld   (rght_ld),
        .ld_vld    (ld_vld),
        .en_steer  (en_steer),
        .rider_off (rider_off)
    );

    always #10 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    always @(posedge clk) begin
        vld_d1 <= ld_vld;
        vld_d2 <= vld_d1;
    end

    always @(negedge clk) begin
        if (vld_d2 && !rst) begin
            if (sb_q.size() == 0) begin
                check_val("sb_underflow", 32'd1, 32'd0);
            end else begin
                txn_t t;
                t = sb_q.pop_front();
                check_val({t.tag, "_en"},   {31'd0, en_steer},  {31'd0, t.en});
                check_val({t.tag, "_off"},  {31'd0, rider_off}, {31'd0, t.off});
                check_val({t.tag, "_sum"},  {19'd0, dut.sum_q},  {19'd0, t.sum});
                check_val({t.tag, "_diff"}, {19'd0, dut.diff_q}, {19'd0, t.diff});
                $display("txn %-10s sum=%03h diff=%03h en_steer=%0b rider_off=%0b (exp %0b/%0b)",
                         t.tag, dut.sum_q, dut.diff_q, en_steer, rider_off, t.en, t.off);
            end
        end
    end

    // Strobe one sample pair; returns 1 ns after the sampling edge.
    task automatic drive(input string tag, input logic [11:0] l, input logic [11:0] r,
                         input logic exp_en, input logic exp_off);
        txn_t t;
        logic [12:0] s, d;
        s = {1'b0, l} + {1'b0, r};
        d = (l >= r) ? {1'b0, l - r} : {1'b0, r - l};
        t.tag = tag; t.en = exp_en; t.off = exp_off; t.sum = s; t.diff = d;
        @(negedge clk);
        lft_ld  = l;
        rght_ld = r;
        ld_vld  = 1'b1;
        sb_q.push_back(t);
        @(posedge clk);
        #1 ld_vld = 1'b0;
    endtask

    task automatic settle();
        repeat (3) @(negedge clk);
    endtask

    // Count edges until en_steer rises and compare with the expected edge count.
    task automatic wait_steer(input string tag, input int exp_edges);
        int n;
        bit seen;
        seen = 1'b0;
        n = 0;
        while (!seen && n < exp_edges + 16) begin
            @(posedge clk);
            #1;
            n++;
            if (en_steer) seen = 1'b1;
        end
        check_val({tag, "_seen"}, {31'd0, seen}, 32'd1);
        check_val({tag, "_edges"}, n, exp_edges);
        $display("txn %-10s en_steer after %0d edges (exp %0d)", tag, n, exp_edges);
    endtask

    task automatic jump_tmr_near_full();
        @(negedge clk);
        force dut.tmr_q = TMR_ALL - 26'd64;
        #1 release dut.tmr_q;
    endtask

    initial begin
        #25;
        check_val("rst_off",  {31'd0, rider_off}, 32'd1);
        check_val("rst_en",   {31'd0, en_steer},  32'd0);
        check_val("rst_sum",  {19'd0, dut.sum_q}, 32'd0);
        check_val("rst_tmr",  {6'd0, dut.tmr_q},  32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Mount: WAIT at edge A+1 with tmr=0, STEER_EN 2^15 edges after that.
        drive("mount", 12'h180, 12'h180, 1'b0, 1'b0);
`ifdef RIDER_FAST_SIM_EN
        wait_steer("settle1", (1 << 15) + 1);
`else
        repeat ((1 << 15) + 20) @(posedge clk);
        #1 check_val("no_early", {31'd0, en_steer}, 32'd0);
        jump_tmr_near_full();
        wait_steer("settle1", 65);
`endif
        settle();

        drive("hyst_band", 12'h0E8, 12'h0E8, 1'b1, 1'b0);
        settle();
        drive("hyst_off", 12'h0D8, 12'h0D8, 1'b0, 1'b1);
        settle();

        drive("mount2", 12'h180, 12'h180, 1'b0, 1'b0);
        settle();
        drive("unbal", 12'h300, 12'h080, 1'b0, 1'b0);
        settle();
        check_val("unbal_tmr", {6'd0, dut.tmr_q}, 32'd0);
        // Rebalance: tmr is 0 at the sampling edge and counts from the next one.
        drive("rebal", 12'h180, 12'h180, 1'b0, 1'b0);
`ifdef RIDER_FAST_SIM_EN
        wait_steer("settle2", 1 << 15);
`else
        repeat (200) @(posedge clk);
        #1 check_val("rebal_tmr", {6'd0, dut.tmr_q}, 32'd200);
        jump_tmr_near_full();
        wait_steer("settle2", 65);
`endif
        settle();

        drive("step_off", 12'h400, 12'h010, 1'b0, 1'b0);
        settle();
        // diff 0x300 exceeds sum>>2 = 0x140, so WAIT holds with the timer pinned at 0.
        drive("heavy_unb", 12'h400, 12'h100, 1'b0, 1'b0);
        repeat (5) @(negedge clk);
        check_val("heavy_tmr", {6'd0, dut.tmr_q}, 32'd0);
        check_val("heavy_en",  {31'd0, en_steer}, 32'd0);

        // Low weight and unbalanced together: dismount takes precedence.
        drive("off_prec", 12'h1A0, 12'h000, 1'b0, 1'b1);
        settle();

        drive("mount3", 12'h180, 12'h180, 1'b0, 1'b0);
        repeat (32'h1001) @(posedge clk);
        #1 check_val("tmr_1000", {6'd0, dut.tmr_q}, 32'h1000);
        #2 rst = 1'b1;
        #1;
        check_val("arst_off",  {31'd0, rider_off}, 32'd1);
        check_val("arst_en",   {31'd0, en_steer},  32'd0);
        check_val("arst_tmr",  {6'd0, dut.tmr_q},  32'd0);
        check_val("arst_sum",  {19'd0, dut.sum_q}, 32'd0);
        check_val("arst_diff", {19'd0, dut.diff_q}, 32'd0);
        $display("txn async_rst rider_off=%0b en_steer=%0b tmr=%0h", rider_off, en_steer, dut.tmr_q);
        repeat (3) @(negedge clk);
        check_val("sb_empty", sb_q.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
